// File: rtl/seg_scan_mux_if.sv
// -----------------------------------------------------------------------------
// seg_scan_mux_if
// Bundle between the per-road state machines and the seven-segment scanner.
//
//   countdown        [7*N_CH]  channel i seconds at [7i+6:7i]
//   state            [4*N_CH]  channel i light state at [4i+3:4i]
//   blink_en         [N_CH]    channel i blinks when set
//   lz_sup           [1]       blank the tens digit when countdown < 10
//   duanma           [8]       segment code, active-low, bit 7 = dp
//   shumaguan_choose [3*N_CH]  digit enables, active-low
//   frame_tick       [1]       one-cycle pulse on the last cycle of a frame
//
// master: the side that supplies channel data and watches the pins.
// slave : the scanner itself.
// -----------------------------------------------------------------------------
interface seg_scan_mux_if #(
    parameter int N_CH = 2
);
    logic [7*N_CH-1:0] countdown;
    logic [4*N_CH-1:0] state;
    logic [N_CH-1:0]   blink_en;
    logic              lz_sup;
    logic [7:0]        duanma;
    logic [3*N_CH-1:0] shumaguan_choose;
    logic              frame_tick;

    modport master (
        output countdown, state, blink_en, lz_sup,
        input  duanma, shumaguan_choose, frame_tick
    );

    modport slave (
        input  countdown, state, blink_en, lz_sup,
        output duanma, shumaguan_choose, frame_tick
    );
endinterface

// File: rtl/seg_scan_mux.sv
// -----------------------------------------------------------------------------
// seg_scan_mux
// Time-multiplexed driver for common-anode seven-segment displays. Each of the
// N_CH channels owns three digits: status glyph, countdown tens, countdown
// ones. Every digit gets a slot of DIV cycles; the first BLANK cycles of a
// slot keep all digits dark to avoid ghosting. Channels can blink with a half
// period of BLINK_FRAMES full frames.
//
//   clk   system clock
//   rst   asynchronous, active-low reset
//   bus   seg_scan_mux_if.slave (channel inputs, segment/digit outputs)
// -----------------------------------------------------------------------------
module seg_scan_mux #(
    parameter int N_CH         = 2,
    parameter int DIV          = 50000,
    parameter int BLANK        = 4,
    parameter int BLINK_FRAMES = 64
) (
    input  logic           clk,
    input  logic           rst,
    seg_scan_mux_if.slave  bus
);
    localparam int D      = 3 * N_CH;
    localparam int SLOT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DIG_W  = $clog2(D);
    localparam int FRM_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [D-1:0] ONE_HOT0 = {{(D-1){1'b0}}, 1'b1};

    // Segment codes, active-low.
    function automatic logic [7:0] f_digit(input logic [6:0] v);
        case (v)
            7'd0:    f_digit = 8'hC0;
            7'd1:    f_digit = 8'hF9;
            7'd2:    f_digit = 8'hA4;
            7'd3:    f_digit = 8'hB0;
            7'd4:    f_digit = 8'h99;
            7'd5:    f_digit = 8'h92;
            7'd6:    f_digit = 8'h82;
            7'd7:    f_digit = 8'hF8;
            7'd8:    f_digit = 8'h80;
            7'd9:    f_digit = 8'h90;
            default: f_digit = 8'hFF;
        endcase
    endfunction

    function automatic logic [7:0] f_glyph(input logic [3:0] s);
        case (s)
            4'd0:    f_glyph = 8'h0F;   // r
            4'd1:    f_glyph = 8'h47;   // L
            4'd2:    f_glyph = 8'h11;   // y
            4'd3:    f_glyph = 8'h10;   // g
            4'd4:    f_glyph = 8'h11;   // y
            default: f_glyph = 8'hFF;
        endcase
    endfunction

    // Scan position
    logic [SLOT_W-1:0] r_slot;
    logic [DIG_W-1:0]  r_digit;
    logic [FRM_W-1:0]  r_frame;
    logic              r_blink_on;

    // Inputs captured at slot cycle 0
    logic [7*N_CH-1:0] r_cd_s;
    logic [4*N_CH-1:0] r_st_s;
    logic [N_CH-1:0]   r_be_s;
    logic              r_lz_s;

    // Registered outputs
    logic [7:0]        r_duanma;
    logic [D-1:0]      r_choose;
    logic              r_frame_tick;

    logic              w_slot_first;
    logic              w_slot_last;
    logic              w_digit_last;
    logic              w_frame_end;
    logic              w_frame_wrap;
    logic              w_in_blank;
    logic [7*N_CH-1:0] w_cd;
    logic [4*N_CH-1:0] w_st;
    logic [N_CH-1:0]   w_be;
    logic              w_lz;
    logic [7:0]        w_code [D];
    logic [7:0]        w_sel_code;
    logic [D-1:0]      w_choose;

    assign w_slot_first = (r_slot == '0);
    assign w_slot_last  = (r_slot == SLOT_W'(DIV - 1));
    assign w_digit_last = (r_digit == DIG_W'(D - 1));
    assign w_frame_end  = w_slot_last & w_digit_last;
    assign w_frame_wrap = (r_frame == FRM_W'(BLINK_FRAMES - 1));

    // On slot cycle 0 the capture registers are only being loaded, so the
    // live inputs are used directly. This matters only when BLANK = 0 and
    // the digit must light on the very edge that samples its data.
    assign w_cd = w_slot_first ? bus.countdown : r_cd_s;
    assign w_st = w_slot_first ? bus.state     : r_st_s;
    assign w_be = w_slot_first ? bus.blink_en  : r_be_s;
    assign w_lz = w_slot_first ? bus.lz_sup    : r_lz_s;

    generate
        if (BLANK == 0) begin : g_no_blank
            assign w_in_blank = 1'b0;
        end else begin : g_blank
            assign w_in_blank = (r_slot < SLOT_W'(BLANK));
        end
    endgenerate

    // Per-channel decode of the three digit codes.
    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [6:0] w_val;
            logic [3:0] w_state;
            logic       w_dark;
            logic       w_over;
            logic [6:0] w_tens;
            logic [6:0] w_ones;

            assign w_val   = w_cd[7*gi +: 7];
            assign w_state = w_st[4*gi +: 4];
            assign w_dark  = w_be[gi] & ~r_blink_on;
            assign w_over  = (w_val > 7'd99);
            assign w_tens  = w_val / 7'd10;
            assign w_ones  = w_val % 7'd10;

            assign w_code[3*gi+0] = w_dark ? 8'hFF : f_glyph(w_state);
            assign w_code[3*gi+1] = w_dark                      ? 8'hFF :
                                    w_over                      ? 8'hBF :
                                    (w_lz && w_val <= 7'd9)     ? 8'hFF :
                                                                  f_digit(w_tens);
            assign w_code[3*gi+2] = w_dark ? 8'hFF :
                                    w_over ? 8'hBF : f_digit(w_ones);
        end
    endgenerate

    assign w_sel_code = w_code[r_digit];
    assign w_choose   = ~(ONE_HOT0 << r_digit);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_slot       <= '0;
            r_digit      <= '0;
            r_frame      <= '0;
            r_blink_on   <= 1'b1;
            r_cd_s       <= '0;
            r_st_s       <= '0;
            r_be_s       <= '0;
            r_lz_s       <= 1'b0;
            r_duanma     <= 8'hFF;
            r_choose     <= '1;
            r_frame_tick <= 1'b0;
        end else begin
            if (w_slot_last) begin
                r_slot  <= '0;
                r_digit <= w_digit_last ? '0 : r_digit + DIG_W'(1);
            end else begin
                r_slot  <= r_slot + SLOT_W'(1);
            end

            if (w_frame_end) begin
                if (w_frame_wrap) begin
                    r_frame    <= '0;
                    r_blink_on <= ~r_blink_on;
                end else begin
                    r_frame    <= r_frame + FRM_W'(1);
                end
            end

            if (w_slot_first) begin
                r_cd_s <= bus.countdown;
                r_st_s <= bus.state;
                r_be_s <= bus.blink_en;
                r_lz_s <= bus.lz_sup;
            end

            if (w_in_blank) begin
                r_duanma <= 8'hFF;
                r_choose <= '1;
            end else begin
                r_duanma <= w_sel_code;
                r_choose <= w_choose;
            end

            r_frame_tick <= w_frame_end;
        end
    end

    assign bus.duanma           = r_duanma;
    assign bus.shumaguan_choose = r_choose;
    assign bus.frame_tick       = r_frame_tick;

endmodule
